// File: rtl/axi_write_ctrl_pkg.sv
// Shared encodings for the AXI store sequencer: FSM states, AXI constants, size codes.
package axi_write_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_B,
        ST_RESP
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    // Byte-enable pattern for a right-justified access of the given size.
    function automatic logic [7:0] size_mask(input logic [2:0] size);
        case (size)
            SIZE_B:  size_mask = 8'h01;
            SIZE_H:  size_mask = 8'h03;
            SIZE_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/axi_write_ctrl_wr_align.sv
// Lane alignment of a store onto the 64-bit bus: shifted data, byte strobe, misalignment flag.
module axi_write_ctrl_wr_align
    import axi_write_ctrl_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [2:0]  size_i,
    input  logic [63:0] data_i,
    output logic [63:0] data_o,
    output logic [7:0]  strb_o,
    output logic        misalign_o
);

    assign data_o = data_i << {off_i, 3'b000};
    assign strb_o = size_mask(size_i) << off_i;

    // Illegal sizes are folded into the misaligned flag so the FSM has a single error path.
    always_comb begin
        case (size_i)
            SIZE_B:  misalign_o = 1'b0;
            SIZE_H:  misalign_o = off_i[0];
            SIZE_W:  misalign_o = |off_i[1:0];
            SIZE_D:  misalign_o = |off_i;
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_write_ctrl.sv
// Single-outstanding store sequencer: MEM store request -> AXI AW/W/B -> one completion to MEM.
module axi_write_ctrl
    import axi_write_ctrl_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 64,
    parameter int          ID_W   = 4,
    parameter int unsigned WR_ID  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_wsize,
    input  logic              mem_wreq_valid,
    output logic              mem_wreq_ready,
    output logic              mem_wresp_valid,
    input  logic              mem_wresp_ready,
    input  logic              io_master_awready,
    output logic              io_master_awvalid,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [ID_W-1:0]   io_master_awid,
    output logic [7:0]        io_master_awlen,
    output logic [2:0]        io_master_awsize,
    output logic [1:0]        io_master_awburst,
    input  logic              io_master_wready,
    output logic              io_master_wvalid,
    output logic [DATA_W-1:0] io_master_wdata,
    output logic [7:0]        io_master_wstrb,
    output logic              io_master_wlast,
    output logic              io_master_bready,
    input  logic              io_master_bvalid,
    input  logic [1:0]        io_master_bresp,
    input  logic [ID_W-1:0]   io_master_bid,
    output logic              wr_error
);

    localparam logic [ID_W-1:0] WR_ID_L = ID_W'(WR_ID);

    wr_state_e         state_q;
    logic              aw_done_q, w_done_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [2:0]        awsize_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wstrb_q;
    logic              wr_error_q;

    logic [63:0] al_data;
    logic [7:0]  al_strb;
    logic        al_mis;
    logic        aw_hs, w_hs;

    axi_write_ctrl_wr_align u_align (
        .off_i      (mem_waddr[2:0]),
        .size_i     (mem_wsize),
        .data_i     (mem_wdata),
        .data_o     (al_data),
        .strb_o     (al_strb),
        .misalign_o (al_mis)
    );

    // Handshake outputs decode straight from state/flag flops, no input-to-output paths.
    assign mem_wreq_ready    = (state_q == ST_IDLE);
    assign mem_wresp_valid   = (state_q == ST_RESP);
    assign io_master_awvalid = (state_q == ST_SEND) && !aw_done_q;
    assign io_master_wvalid  = (state_q == ST_SEND) && !w_done_q;
    assign io_master_bready  = (state_q == ST_WAIT_B);

    assign io_master_awaddr  = awaddr_q;
    assign io_master_awsize  = awsize_q;
    assign io_master_awid    = WR_ID_L;
    assign io_master_awlen   = 8'd0;
    assign io_master_awburst = AXI_BURST_FIXED;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;
    assign wr_error          = wr_error_q;

    assign aw_hs = io_master_awvalid && io_master_awready;
    assign w_hs  = io_master_wvalid && io_master_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awaddr_q   <= '0;
            awsize_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_wreq_valid) begin
                        awaddr_q <= mem_waddr;
                        awsize_q <= mem_wsize;
                        wdata_q  <= al_data;
                        wstrb_q  <= al_strb;
                        // Misaligned/illegal stores complete locally with an error.
                        if (al_mis) begin
                            wr_error_q <= 1'b1;
                            state_q    <= ST_RESP;
                        end else begin
                            state_q    <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                        state_q <= ST_WAIT_B;
                end
                ST_WAIT_B: begin
                    if (io_master_bvalid) begin
                        wr_error_q <= (io_master_bresp != AXI_RESP_OKAY) || (io_master_bid != WR_ID_L);
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_wresp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_ctrl.sv
// Randomized bench for axi_write_ctrl against a transaction-level model, plus directed literal checks.
module tb_axi_write_ctrl;

    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [2:0]  mem_wsize;
    logic        mem_wreq_valid, mem_wreq_ready, mem_wresp_valid, mem_wresp_ready;
    logic        io_master_awready, io_master_awvalid;
    logic [31:0] io_master_awaddr;
    logic [3:0]  io_master_awid;
    logic [7:0]  io_master_awlen;
    logic [2:0]  io_master_awsize;
    logic [1:0]  io_master_awburst;
    logic        io_master_wready, io_master_wvalid;
    logic [63:0] io_master_wdata;
    logic [7:0]  io_master_wstrb;
    logic        io_master_wlast, io_master_bready, io_master_bvalid;
    logic [1:0]  io_master_bresp;
    logic [3:0]  io_master_bid;
    logic        wr_error;

    axi_write_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wsize(mem_wsize),
        .mem_wreq_valid(mem_wreq_valid), .mem_wreq_ready(mem_wreq_ready),
        .mem_wresp_valid(mem_wresp_valid), .mem_wresp_ready(mem_wresp_ready),
        .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
        .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
        .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
        .io_master_awburst(io_master_awburst),
        .io_master_wready(io_master_wready), .io_master_wvalid(io_master_wvalid),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast),
        .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
        .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
        .wr_error(wr_error)
    );

    int cyc = 0;
    bit rst_at_edge = 1'b0;
    int n_chk = 0, n_err = 0;

    // Slave / MEM-side behaviour knobs
    int aw_pct = 100, w_pct = 100, b_pct = 100, r_pct = 100, berr_pct = 0, bid_pct = 0;
    int aw_block = 0, w_block = 0, r_block = 0;
    bit b_force_err = 1'b0;

    // Model state for the single outstanding store
    bit          act = 1'b0, mis = 1'b0, aw_seen = 1'b0, w_seen = 1'b0, b_seen = 1'b0;
    bit          merr = 1'b0;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [63:0] m_wdata;
    logic [7:0]  m_strb;
    int          acc_cyc = 0, resp_cyc = -1, b_cyc = -1, cnt_awv = 0, cnt_wv = 0, cnt_rv = 0;
    logic [31:0] cap_awaddr;
    logic [2:0]  cap_awsize;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Byte-level view of a store: which lanes it covers and where its bytes land.
    function automatic void model_req(input logic [31:0] a, input logic [63:0] d, input logic [2:0] s,
                                      output logic [63:0] wd, output logic [7:0] st, output bit m);
        int off, n;
        logic [127:0] wide;
        off  = int'(a % 32'd8);
        n    = 1 << s;
        wide = {64'd0, d} << (8 * off);
        wd   = wide[63:0];
        st   = '0;
        for (int i = 0; i < 8; i++)
            if (i >= off && i < off + n) st[i] = 1'b1;
        m = (s > 3) || (off % n != 0);
    endfunction

    // Slave and MEM-response drivers
    initial begin
        forever begin
            @(posedge clk); #1;
            io_master_awready = (cyc >= aw_block) && ($urandom_range(99) < aw_pct);
            io_master_wready  = (cyc >= w_block) && ($urandom_range(99) < w_pct);
            io_master_bvalid  = ($urandom_range(99) < b_pct);
            io_master_bresp   = b_force_err ? 2'b10 :
                                (($urandom_range(99) < berr_pct) ? 2'($urandom_range(3, 1)) : 2'b00);
            io_master_bid     = ($urandom_range(99) < bid_pct) ? 4'($urandom_range(15, 1)) : 4'd0;
            mem_wresp_ready   = (cyc >= r_block) && ($urandom_range(99) < r_pct);
        end
    end

    // Compare process: every cycle, DUT outputs vs. what the model says must be visible now.
    initial begin
        bit e_rdy, e_awv, e_wv, e_br, e_rv;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                act  = 1'b0;
                merr = 1'b0;
            end
            e_rdy = !act;
            e_awv = act && !mis && !aw_seen;
            e_wv  = act && !mis && !w_seen;
            e_br  = act && !mis && aw_seen && w_seen && !b_seen;
            e_rv  = act && (mis || b_seen);
            chk("mem_wreq_ready", mem_wreq_ready, e_rdy);
            chk("awvalid", io_master_awvalid, e_awv);
            chk("wvalid", io_master_wvalid, e_wv);
            chk("bready", io_master_bready, e_br);
            chk("mem_wresp_valid", mem_wresp_valid, e_rv);
            chk("wr_error", wr_error, merr);
            if (e_awv) begin
                chk("awaddr", io_master_awaddr, m_addr);
                chk("awsize", io_master_awsize, m_size);
                chk("awid", io_master_awid, 0);
                chk("awlen", io_master_awlen, 0);
                chk("awburst", io_master_awburst, 0);
                cnt_awv++;
            end
            if (e_wv) begin
                chk("wdata", io_master_wdata, m_wdata);
                chk("wstrb", io_master_wstrb, m_strb);
                chk("wlast", io_master_wlast, 1);
                cnt_wv++;
            end
            if (e_rv) begin
                cnt_rv++;
                if (resp_cyc < 0) resp_cyc = cyc;
            end
            if (e_br && b_cyc < 0) b_cyc = cyc;

            if (!rst) begin
                if (e_rdy && mem_wreq_valid) begin
                    act = 1'b1;
                    model_req(mem_waddr, mem_wdata, mem_wsize, m_wdata, m_strb, mis);
                    m_addr  = mem_waddr;
                    m_size  = mem_wsize;
                    aw_seen = 1'b0; w_seen = 1'b0; b_seen = 1'b0;
                    if (mis) merr = 1'b1;
                    acc_cyc = cyc; resp_cyc = -1; b_cyc = -1;
                    cnt_awv = 0; cnt_wv = 0; cnt_rv = 0;
                    cap_awaddr = '0; cap_awsize = '0; cap_wdata = '0; cap_wstrb = '0;
                end
                if (e_awv && io_master_awready) begin
                    aw_seen    = 1'b1;
                    cap_awaddr = io_master_awaddr;
                    cap_awsize = io_master_awsize;
                end
                if (e_wv && io_master_wready) begin
                    w_seen    = 1'b1;
                    cap_wdata = io_master_wdata;
                    cap_wstrb = io_master_wstrb;
                end
                if (e_br && io_master_bvalid) begin
                    b_seen = 1'b1;
                    merr   = (io_master_bresp != 2'b00) || (io_master_bid != 4'd0);
                end
                if (e_rv && mem_wresp_ready) act = 1'b0;
            end
        end
    end

    // One store end to end; aw_dly / r_dly (>=0) stall AWREADY / wresp_ready until accept+dly.
    task automatic store(input logic [31:0] a, input logic [63:0] d, input logic [2:0] s,
                         input int aw_dly, input int r_dly);
        int t;
        if (aw_dly >= 0) aw_block = BIG;
        if (r_dly >= 0)  r_block  = BIG;
        @(posedge clk); #1;
        mem_wreq_valid = 1'b1; mem_waddr = a; mem_wdata = d; mem_wsize = s;
        t = 0;
        do begin @(negedge clk); t++; end while (!mem_wreq_ready && t < 100);
        n_chk++;
        if (!mem_wreq_ready) begin n_err++; $display("FAIL accept_timeout: got 0 want 1"); end
        if (aw_dly >= 0) aw_block = cyc + aw_dly;
        if (r_dly >= 0)  r_block  = cyc + r_dly;
        @(posedge clk); #1;
        mem_wreq_valid = 1'b0;
        mem_waddr = $urandom; mem_wdata = {$urandom, $urandom}; mem_wsize = 3'($urandom);
        t = 0;
        do begin @(negedge clk); t++; end while (!(mem_wresp_valid && mem_wresp_ready) && t < 500);
        n_chk++;
        if (!(mem_wresp_valid && mem_wresp_ready)) begin
            n_err++; $display("FAIL completion_timeout: got 0 want 1");
        end
        @(posedge clk); #1;
        aw_block = 0; r_block = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  s;
        mem_wreq_valid = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_wsize = '0;
        mem_wresp_ready = 1'b0; io_master_awready = 1'b0; io_master_wready = 1'b0;
        io_master_bvalid = 1'b0; io_master_bresp = '0; io_master_bid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset awvalid", io_master_awvalid, 0);
        chk("reset wr_error", wr_error, 0);
        chk("reset wstrb", io_master_wstrb, 0);

        // SW aligned, everything ready
        store(32'h8000_0004, 64'h1122_3344, 3'd2, -1, -1);
        chk("sw awaddr", cap_awaddr, 32'h8000_0004);
        chk("sw awsize", cap_awsize, 2);
        chk("sw wdata", cap_wdata, 64'h1122_3344_0000_0000);
        chk("sw wstrb", cap_wstrb, 8'hF0);
        chk("sw latency", 64'(resp_cyc - acc_cyc), 3);
        chk("sw wr_error", wr_error, 0);

        // SB at byte 3
        store(32'h8000_0003, 64'hAB, 3'd0, -1, -1);
        chk("sb wdata", cap_wdata, 64'h0000_0000_AB00_0000);
        chk("sb wstrb", cap_wstrb, 8'h08);

        // W completes first, AW held off until accept+4
        store(32'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 3'd3, 4, -1);
        chk("awdly wvalid cycles", 64'(cnt_wv), 1);
        chk("awdly awvalid cycles", 64'(cnt_awv), 4);
        chk("awdly first bready", 64'(b_cyc - acc_cyc), 5);
        chk("awdly awaddr", cap_awaddr, 32'h8000_0010);
        chk("awdly wstrb", cap_wstrb, 8'hFF);

        // Misaligned halfword: no AXI traffic, immediate error completion
        store(32'h8000_0001, 64'h5566, 3'd1, -1, -1);
        chk("mis awvalid cycles", 64'(cnt_awv), 0);
        chk("mis wvalid cycles", 64'(cnt_wv), 0);
        chk("mis latency", 64'(resp_cyc - acc_cyc), 1);
        chk("mis wr_error", wr_error, 1);

        // SLVERR then a clean store
        b_force_err = 1'b1;
        store(32'h8000_0008, 64'h77, 3'd0, -1, -1);
        chk("slverr wr_error", wr_error, 1);
        b_force_err = 1'b0;
        store(32'h8000_000C, 64'h1234, 3'd1, -1, -1);
        chk("after slverr wr_error", wr_error, 0);

        // MEM stalls the completion for 5 cycles
        store(32'h8000_0020, 64'h99, 3'd2, -1, 8);
        chk("resp hold cycles", 64'(cnt_rv), 6);

        // Reset while in SEND
        aw_block = BIG; w_block = BIG;
        @(posedge clk); #1;
        mem_wreq_valid = 1'b1; mem_waddr = 32'h8000_0040; mem_wsize = 3'd3; mem_wdata = 64'h0102;
        @(negedge clk);
        chk("rst ready before", mem_wreq_ready, 1);
        @(posedge clk); #1;
        mem_wreq_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst awvalid in SEND", io_master_awvalid, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst awvalid after", io_master_awvalid, 0);
        chk("rst wvalid after", io_master_wvalid, 0);
        chk("rst ready after", mem_wreq_ready, 1);
        chk("rst wresp_valid after", mem_wresp_valid, 0);
        aw_block = 0; w_block = 0;

        // Random traffic
        berr_pct = 20; bid_pct = 10;
        for (int n = 0; n < 150; n++) begin
            aw_pct = $urandom_range(100, 30);
            w_pct  = $urandom_range(100, 30);
            b_pct  = $urandom_range(100, 30);
            r_pct  = $urandom_range(100, 30);
            s = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
            a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            if ($urandom_range(9) < 7 && s <= 3) a = a & ~((32'd1 << s) - 32'd1);
            store(a, {$urandom, $urandom}, s, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
